// File: rtl/prco_debug_uart_tx.sv
// Debug byte tap for prco_core: captures q_debug on each rising instruction strobe
// into a small FIFO and streams the bytes out as 8N1 UART frames on one TX pin.
module prco_debug_uart_tx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_instr_clk,
  input  logic [7:0]         i_debug,
  output logic               q_tx,
  output logic               q_busy,
  output logic [FIFO_AW:0]   q_fifo_count,
  output logic               q_fifo_full,
  output logic               q_overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   BAUD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   BAUD_ONE  = CNT_W'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   baud_r;
  logic [2:0]         bit_r;
  logic [7:0]         shift_r;
  logic               prev_r;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [7:0]         mem_r [FIFO_DEPTH];

  logic               push_req_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               drop_s;
  logic [FIFO_AW:0]   count_next_s;

  // Push/pop arbitration; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    push_req_s = i_en & i_instr_clk & ~prev_r;
    pop_s      = (state_r == ST_IDLE) && (q_fifo_count != CNT_ZERO);
    push_ok_s  = push_req_s & (~q_fifo_full | pop_s);
    drop_s     = push_req_s & q_fifo_full & ~pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = q_fifo_count + CNT_ONE;
      2'b01:   count_next_s = q_fifo_count - CNT_ONE;
      default: count_next_s = q_fifo_count;
    endcase
  end

  // Strobe edge register, FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_r       <= 1'b0;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      q_fifo_count <= CNT_ZERO;
      q_fifo_full  <= 1'b0;
      q_overflow   <= 1'b0;
    end else begin
      prev_r       <= i_instr_clk;
      q_fifo_count <= count_next_s;
      q_fifo_full  <= (count_next_s == CNT_DEPTH);
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        q_overflow <= 1'b1;
      end
    end
  end

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= i_debug;
    end
  end

  // Frame serialiser; q_tx and q_busy are set together with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      q_tx    <= 1'b1;
      q_busy  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            baud_r  <= BAUD_ZERO;
            state_r <= ST_START;
            q_tx    <= 1'b0;
            q_busy  <= 1'b1;
          end else begin
            q_tx    <= 1'b1;
            q_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            state_r <= ST_DATA;
            q_tx    <= shift_r[0];
          end else begin
            baud_r  <= baud_r + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= BAUD_ZERO;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_r <= ST_STOP;
              q_tx    <= 1'b1;
            end else begin
              bit_r   <= bit_r + 3'd1;
              q_tx    <= shift_r[1];
            end
          end else begin
            baud_r  <= baud_r + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= BAUD_ZERO;
            state_r <= ST_IDLE;
            q_busy  <= 1'b0;
          end else begin
            baud_r  <= baud_r + BAUD_ONE;
          end
          q_tx <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          baud_r  <= BAUD_ZERO;
          q_tx    <= 1'b1;
          q_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prco_debug_uart_tx.sv
// Bench for prco_debug_uart_tx: queue/frame-timer reference model compared every cycle,
// a line decoder for frame contents and gaps, directed scenarios then random traffic.
module tb_prco_debug_uart_tx;
  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, en, strb;
  logic [7:0]    dbg;
  logic          tx, busy, full, ovf;
  logic [AW:0]   cnt;

  prco_debug_uart_tx #(
    .CLK_HZ(400), .BAUD(100), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_instr_clk(strb), .i_debug(dbg),
    .q_tx(tx), .q_busy(busy), .q_fifo_count(cnt), .q_fifo_full(full), .q_overflow(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: a byte queue plus a cycle index into the current frame
  logic [7:0] m_q[$];
  bit         m_active = 1'b0, m_ovf = 1'b0, m_prev = 1'b0, m_valid = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;

  // line decoder state and its logs
  bit         d_active = 1'b0, d_have_prev = 1'b0;
  int         d_t = 0, d_hi = 0, d_gap = -1;
  logic [7:0] d_byte = 8'h00;
  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic model_step();
    bit pre_active, full_pre, pop, push_req;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0; m_t = 0; m_ovf = 1'b0; m_prev = 1'b0; m_valid = 1'b1;
    end else begin
      push_req   = en && strb && !m_prev;
      m_prev     = strb;
      pre_active = m_active;
      full_pre   = (m_q.size() == DEPTH);
      pop        = !pre_active && (m_q.size() > 0);
      if (m_active) begin
        m_t++;
        if (m_t == 10*C) m_active = 1'b0;
      end
      if (pop) begin
        m_cur = m_q.pop_front();
        m_active = 1'b1;
        m_t = 0;
      end
      if (push_req) begin
        if (!full_pre || pop) m_q.push_back(dbg);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    if (m_valid) begin
      chk("tx", 32'(tx), 32'(exp_tx()));
      chk("busy", 32'(busy), 32'(m_active));
      chk("count", 32'(cnt), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(ovf), 32'(m_ovf));
    end
  endtask

  task automatic decoder_step();
    if (rst) begin
      d_active = 1'b0; d_have_prev = 1'b0; d_hi = 0;
    end else if (d_active) begin
      d_t++;
      for (int k = 1; k <= 8; k++)
        if (d_t == k*C + C/2) d_byte[k-1] = tx;
      if (d_t == 10*C - 1) begin
        rx_q.push_back(d_byte);
        gap_q.push_back(d_gap);
        d_active = 1'b0; d_hi = 0; d_have_prev = 1'b1;
      end
    end else if (tx === 1'b0) begin
      d_active = 1'b1; d_t = 0;
      d_gap = d_have_prev ? d_hi : -1;
    end else begin
      d_hi++;
    end
  endtask

  // one clock: model sees the inputs at the edge, outputs are checked on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    decoder_step();
    if (int'(cnt) > peak) peak = int'(cnt);
    #1;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return 32'(rx_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gap_at(input int i);
    if (i < gap_q.size()) return 32'(gap_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      cyc();
      if (!busy && cnt == '0 && !d_active) quiet++;
      else quiet = 0;
    end
    chk({name, "_drained"}, {30'd0, busy, d_active}, 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    dbg = b; strb = 1'b1; cyc();
    strb = 1'b0; cyc();
  endtask

  initial begin
    int base, first_low, busy_n;
    rst = 1'b1; en = 1'b1; strb = 1'b0; dbg = 8'h00;

    // 1: reset with the strobe toggling, then one cycle after release
    for (int i = 0; i < 2; i++) begin
      strb = (i == 0);
      cyc();
      chk("t1_tx", 32'(tx), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_count", 32'(cnt), 32'd0);
      chk("t1_ovf", 32'(ovf), 32'd0);
    end
    rst = 1'b0; strb = 1'b0;
    cyc();
    chk("t1_post_tx", 32'(tx), 32'd1);
    chk("t1_post_count", 32'(cnt), 32'd0);
    cyc();

    // 2: single byte, latency and frame length
    base = rx_q.size(); first_low = 0; busy_n = 0;
    dbg = 8'hA5; strb = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      strb = 1'b0;
      if (tx === 1'b0 && first_low == 0) first_low = k;
      if (busy === 1'b1) busy_n++;
    end
    chk("t2_latency", 32'(first_low), 32'd2);
    chk("t2_busy_cycles", 32'(busy_n), 32'd40);
    chk("t2_frames", 32'(rx_q.size() - base), 32'd1);
    chk("t2_byte", rx_at(base), 32'h0000_00A5);

    // 3: strobe held high gives one push
    base = rx_q.size(); peak = 0;
    dbg = 8'h3C; strb = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    strb = 1'b0;
    wait_idle("t3", 200);
    chk("t3_frames", 32'(rx_q.size() - base), 32'd1);
    chk("t3_byte", rx_at(base), 32'h0000_003C);
    chk("t3_peak", 32'(peak), 32'd1);

    // 4: burst of five, back-to-back frames
    base = rx_q.size();
    for (int b = 1; b <= 5; b++) push(8'(b));
    wait_idle("t4", 400);
    chk("t4_frames", 32'(rx_q.size() - base), 32'd5);
    for (int b = 0; b < 5; b++) chk("t4_byte", rx_at(base + b), 32'(b + 1));
    for (int b = 1; b < 5; b++) chk("t4_gap", gap_at(base + b), 32'd1);
    chk("t4_ovf", 32'(ovf), 32'd0);

    // 5: six pushes into a depth-4 FIFO while the first frame runs
    base = rx_q.size(); peak = 0;
    for (int b = 0; b < 6; b++) push(8'h10 + 8'(b));
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_ovf", 32'(ovf), 32'd1);
    wait_idle("t5", 600);
    chk("t5_peak", 32'(peak), 32'd4);
    chk("t5_frames", 32'(rx_q.size() - base), 32'd5);
    for (int b = 0; b < 5; b++) chk("t5_byte", rx_at(base + b), 32'h10 + 32'(b));
    chk("t5_ovf_sticky", 32'(ovf), 32'd1);

    // 6: reset in the middle of data bit 3 with two bytes queued
    base = rx_q.size();
    for (int b = 0; b < 3; b++) push(8'h61 + 8'(b));
    for (int i = 0; i < 100 && !(d_active && d_t == 4*C + 1); i++) cyc();
    chk("t6_reached_bit3", 32'(d_t), 32'(4*C + 1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_tx", 32'(tx), 32'd1);
    chk("t6_count", 32'(cnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 120; i++) cyc();
    chk("t6_no_frames", 32'(rx_q.size() - base), 32'd0);
    push(8'h5A);
    wait_idle("t6", 200);
    chk("t6_frames", 32'(rx_q.size() - base), 32'd1);
    chk("t6_byte", rx_at(base), 32'h0000_005A);

    // random traffic with sporadic enables and resets, checked by the model
    for (int i = 0; i < 4000; i++) begin
      strb = ($urandom_range(0, 2) == 0);
      en   = ($urandom_range(0, 7) != 0);
      dbg  = 8'($urandom);
      rst  = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; strb = 1'b0; en = 1'b1;
    wait_idle("rand", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
